// File: rtl/vqueue_fetch_ctrl.sv
// vqueue_fetch_ctrl
// Write-side scheduler for the video pixel queue. Fetches one frame of
// framebuffer words from memory in fixed-length bursts and pushes every
// returned beat into the queue write port. A burst is only issued while the
// (synchronized) queue AlmostEmpty flag is high, and a frame_start pulse
// restarts the fetch from the framebuffer base.
//
// Ports:
//   clk, rst          memory/queue write clock, async active-low reset
//   fb_base           framebuffer word base, sampled on frame_start
//   frame_start       one-cycle pulse at vertical blank start
//   q_almost_empty    queue AlmostEmpty, asynchronous to clk
//   q_wr_en, q_data   queue write port (registered, 1 cycle after a beat)
//   mem_req, mem_addr burst read request and burst start word address
//   mem_ack           request accepted pulse
//   mem_rvalid/rdata  read beat stream
//   busy              burst in flight (REQ or DATA)
//   frame_done        last burst of the frame has completed

module vqueue_fetch_ctrl #(
  parameter int unsigned addr_width  = 24,
  parameter int unsigned burst_len   = 8,
  parameter int unsigned frame_words = 24576,
  parameter int unsigned holdoff     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [addr_width-1:0] fb_base,
  input  logic                  frame_start,
  input  logic                  q_almost_empty,
  output logic                  q_wr_en,
  output logic [31:0]           q_data,
  output logic                  mem_req,
  output logic [addr_width-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WL_W   = $clog2(frame_words + 1);
  localparam int unsigned BC_W   = $clog2(burst_len);
  localparam int unsigned HO_W   = (holdoff > 0) ? $clog2(holdoff + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]            r_state;
  logic                  r_ae_m;
  logic                  r_ae_s;
  logic [WL_W-1:0]       r_words_left;
  logic [HO_W-1:0]       r_hold;
  logic [BC_W-1:0]       r_beat_cnt;
  logic                  r_flush;
  logic [addr_width-1:0] r_fb_lat;
  logic [addr_width-1:0] r_mem_addr;
  logic                  r_mem_req;
  logic                  r_busy;
  logic                  r_frame_done;
  logic                  r_q_wr_en;
  logic [DATA_W-1:0]     r_q_data;

  logic [1:0]            w_state_nxt;
  logic [WL_W-1:0]       w_words_left_nxt;
  logic [HO_W-1:0]       w_hold_nxt;
  logic [BC_W-1:0]       w_beat_cnt_nxt;
  logic                  w_flush_nxt;
  logic [addr_width-1:0] w_fb_lat_nxt;
  logic [addr_width-1:0] w_mem_addr_nxt;
  logic                  w_mem_req_nxt;
  logic                  w_busy_nxt;
  logic                  w_frame_done_nxt;
  logic                  w_q_wr_en_nxt;
  logic [DATA_W-1:0]     w_q_data_nxt;
  logic                  w_beat_last;
  logic [WL_W-1:0]       w_words_after;

  // Two-flop synchronizer for the queue AlmostEmpty flag; resets to 1 so a
  // freshly reset controller sees an empty queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ae_m <= 1'b1;
      r_ae_s <= 1'b1;
    end else begin
      r_ae_m <= q_almost_empty;
      r_ae_s <= r_ae_m;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_words_left <= '0;
      r_hold       <= '0;
      r_beat_cnt   <= '0;
      r_flush      <= 1'b0;
      r_fb_lat     <= '0;
      r_mem_addr   <= '0;
      r_mem_req    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b1;
      r_q_wr_en    <= 1'b0;
      r_q_data     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_words_left <= w_words_left_nxt;
      r_hold       <= w_hold_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_flush      <= w_flush_nxt;
      r_fb_lat     <= w_fb_lat_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_q_wr_en    <= w_q_wr_en_nxt;
      r_q_data     <= w_q_data_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_words_left_nxt = r_words_left;
    w_hold_nxt       = r_hold;
    w_beat_cnt_nxt   = r_beat_cnt;
    w_flush_nxt      = r_flush;
    w_fb_lat_nxt     = r_fb_lat;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_req_nxt    = r_mem_req;
    w_frame_done_nxt = r_frame_done;
    w_q_wr_en_nxt    = 1'b0;
    w_q_data_nxt     = r_q_data;
    w_beat_last      = (r_beat_cnt == BC_W'(burst_len - 1));
    w_words_after    = r_words_left - WL_W'(burst_len);

    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_mem_addr_nxt   = fb_base;
          w_words_left_nxt = WL_W'(frame_words);
          w_frame_done_nxt = 1'b0;
          w_hold_nxt       = '0;
        end else if (r_hold != '0) begin
          w_hold_nxt = r_hold - HO_W'(1);
        end else if ((r_words_left != '0) && r_ae_s && !r_flush) begin
          w_state_nxt   = S_REQ;
          w_mem_req_nxt = 1'b1;
        end
      end

      S_REQ: begin
        // A new frame cannot abort a pending request; mark the burst as
        // flushed and restart once its data has drained.
        if (frame_start) begin
          w_flush_nxt  = 1'b1;
          w_fb_lat_nxt = fb_base;
        end
        if (mem_ack) begin
          w_state_nxt    = S_DATA;
          w_mem_req_nxt  = 1'b0;
          w_beat_cnt_nxt = '0;
        end
      end

      S_DATA: begin
        if (frame_start) begin
          w_flush_nxt  = 1'b1;
          w_fb_lat_nxt = fb_base;
        end
        if (mem_rvalid) begin
          // The flush register (not the live pulse) gates writes, so a beat
          // coincident with frame_start is still delivered.
          w_q_wr_en_nxt  = !r_flush;
          if (!r_flush) begin
            w_q_data_nxt = mem_rdata;
          end
          w_beat_cnt_nxt = r_beat_cnt + BC_W'(1);
          if (w_beat_last) begin
            w_state_nxt = S_IDLE;
            if (r_flush || frame_start) begin
              w_mem_addr_nxt   = frame_start ? fb_base : r_fb_lat;
              w_words_left_nxt = WL_W'(frame_words);
              w_frame_done_nxt = 1'b0;
              w_hold_nxt       = '0;
              w_flush_nxt      = 1'b0;
            end else begin
              w_mem_addr_nxt   = r_mem_addr + addr_width'(burst_len);
              w_words_left_nxt = w_words_after;
              w_hold_nxt       = HO_W'(holdoff);
              w_frame_done_nxt = (w_words_after == '0);
            end
          end
        end
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign q_wr_en    = r_q_wr_en;
  assign q_data     = r_q_data;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_vqueue_fetch_ctrl.sv
// Self-checking bench for vqueue_fetch_ctrl (frame_words=16, burst_len=8).
// Stimulus pushes expected queue writes and request addresses into
// scoreboards; a negedge monitor pops and compares them.

module tb_vqueue_fetch_ctrl;

  localparam int unsigned AW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] fb_base;
  logic          frame_start;
  logic          q_almost_empty;
  logic          q_wr_en;
  logic [31:0]   q_data;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          busy;
  logic          frame_done;

  int            checks;
  int            failures;
  int            writes_seen;
  int            cyc;
  int            w0;
  logic          prev_req;
  logic [31:0]   exp_wr[$];
  logic [AW-1:0] exp_addr[$];

  vqueue_fetch_ctrl #(
    .addr_width (AW),
    .burst_len  (8),
    .frame_words(16),
    .holdoff    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fb_base       (fb_base),
    .frame_start   (frame_start),
    .q_almost_empty(q_almost_empty),
    .q_wr_en       (q_wr_en),
    .q_data        (q_data),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of cycles until mem_req is seen, or -1 on timeout.
  task automatic wait_req(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (mem_req === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Serves one burst whose request is already visible. fs_beat: 0 pulses
  // frame_start while waiting for ack, 1..8 pulses it after that beat,
  // anything else means no frame_start.
  task automatic serve_burst(input int ack_dly, input int gap, input int fs_beat,
                             input logic [AW-1:0] fs_base, input logic [AW-1:0] addr,
                             input logic [31:0] seed);
    bit fl;
    fl = 1'b0;
    for (int i = 0; i < ack_dly; i++) begin
      if (fs_beat == 0 && i == 0) begin
        frame_start = 1'b1;
        fb_base     = fs_base;
        fl          = 1'b1;
      end
      tick();
      frame_start = 1'b0;
      chk("req_held", 32'(mem_req), 32'd1);
      chk("req_addr_stable", 32'(mem_addr), 32'(addr));
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("req_drop_after_ack", 32'(mem_req), 32'd0);
    chk("busy_data", 32'(busy), 32'd1);
    for (int b = 1; b <= 8; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = seed + 32'(b);
      if (!fl) exp_wr.push_back(mem_rdata);
      tick();
      mem_rvalid = 1'b0;
      chk("wr_latency", 32'(q_wr_en), 32'(!fl));
      if (b == fs_beat) begin
        frame_start = 1'b1;
        fb_base     = fs_base;
        fl          = 1'b1;
        tick();
        frame_start = 1'b0;
      end
      if (b < 8) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("busy_gap", 32'(busy), 32'd1);
        end
      end
    end
    chk("busy_after_burst", 32'(busy), 32'd0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (q_wr_en === 1'b1) begin
      writes_seen++;
      if (exp_wr.size() == 0) chk("unexpected_write", 32'(q_wr_en), 32'd0);
      else                    chk("wr_data", q_data, exp_wr.pop_front());
    end
    if (mem_req === 1'b1 && prev_req !== 1'b1) begin
      if (exp_addr.size() == 0) chk("unexpected_req", 32'(mem_req), 32'd0);
      else                      chk("req_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
    end
    prev_req <= mem_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks         = 0;
    failures       = 0;
    writes_seen    = 0;
    prev_req       = 1'b0;
    rst            = 1'b1;
    fb_base        = '0;
    frame_start    = 1'b0;
    q_almost_empty = 1'b1;
    mem_ack        = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = '0;

    // Reset values
    #2 rst = 1'b0;
    #2;
    chk("rst_q_wr_en", 32'(q_wr_en), 32'd0);
    chk("rst_q_data", q_data, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Full frame: two bursts, holdoff between them, then frame_done
    fb_base     = 24'h001000;
    frame_start = 1'b1;
    exp_addr.push_back(24'h001000);
    tick();
    frame_start = 1'b0;
    chk("frame_done_clear", 32'(frame_done), 32'd0);
    wait_req(20, cyc);
    chk("req1_timeout", 32'(cyc == -1), 32'd0);
    serve_burst(2, 0, 99, '0, 24'h001000, 32'hA000_0000);
    chk("frame_done_mid", 32'(frame_done), 32'd0);
    exp_addr.push_back(24'h001008);
    wait_req(20, cyc);
    chk("holdoff_min4", 32'(cyc >= 4), 32'd1);
    serve_burst(2, 0, 99, '0, 24'h001008, 32'hB000_0000);
    chk("frame_done_set", 32'(frame_done), 32'd1);
    wait_req(40, cyc);
    chk("no_req_after_done", 32'(mem_req), 32'd0);
    chk("writes_frame1", 32'(writes_seen), 32'd16);

    // AlmostEmpty low blocks requests; rising edge gives request 3 cycles later
    q_almost_empty = 1'b0;
    repeat (3) tick();
    fb_base     = 24'h001000;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("frame_done_clear2", 32'(frame_done), 32'd0);
    wait_req(30, cyc);
    chk("no_req_ae_low", 32'(mem_req), 32'd0);
    exp_addr.push_back(24'h001000);
    q_almost_empty = 1'b1;
    wait_req(10, cyc);
    chk("ae_sync_latency", 32'(cyc), 32'd3);

    // Ack delayed 10 cycles, beats every 3 cycles
    w0 = writes_seen;
    serve_burst(10, 2, 99, '0, 24'h001000, 32'hC000_0000);
    exp_addr.push_back(24'h001008);
    wait_req(20, cyc);
    chk("req3_timeout", 32'(cyc == -1), 32'd0);
    chk("gapped_writes", 32'(writes_seen - w0), 32'd8);

    // frame_start after beat 3: remaining beats dropped, restart at 0x2000
    serve_burst(1, 0, 3, 24'h002000, 24'h001008, 32'hD000_0000);
    chk("flush_frame_done", 32'(frame_done), 32'd0);
    exp_addr.push_back(24'h002000);
    wait_req(10, cyc);
    chk("flush_restart_timeout", 32'(cyc == -1), 32'd0);
    serve_burst(1, 0, 99, '0, 24'h002000, 32'hE000_0000);
    exp_addr.push_back(24'h002008);
    wait_req(20, cyc);
    chk("req_2008_timeout", 32'(cyc == -1), 32'd0);

    // frame_start during REQ: whole burst dropped, restart at 0x3000
    serve_burst(3, 0, 0, 24'h003000, 24'h002008, 32'hF000_0000);
    chk("flush_req_frame_done", 32'(frame_done), 32'd0);
    exp_addr.push_back(24'h003000);
    wait_req(10, cyc);
    chk("req_3000_timeout", 32'(cyc == -1), 32'd0);

    // Reset in the middle of DATA, then stray beats
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int b = 1; b <= 3; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h5000_0000 + 32'(b);
      exp_wr.push_back(mem_rdata);
      tick();
    end
    mem_rvalid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_q_wr_en", 32'(q_wr_en), 32'd0);
    chk("arst_q_data", q_data, 32'd0);
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_mem_addr", 32'(mem_addr), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_frame_done", 32'(frame_done), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_0000 + 32'(i);
      tick();
      chk("stray_beat", 32'(q_wr_en), 32'd0);
    end
    mem_rvalid = 1'b0;
    wait_req(10, cyc);
    chk("no_req_after_rst", 32'(mem_req), 32'd0);

    repeat (2) tick();
    chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    chk("req_queue_drained", 32'(exp_addr.size()), 32'd0);
    chk("total_writes", 32'(writes_seen), 32'd38);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vqueue_fetch_ctrl.md
Name: vqueue_fetch_ctrl

Overview:
- Write-side scheduler for the video pixel queue. Fetches one frame's framebuffer words from memory in fixed-length bursts and pushes them into the queue's write port.
- Issues a burst only while the queue reports AlmostEmpty. Restarts from the frame base on every frame-start pulse.
- Sits between the memory arbiter's read port and the queue write side, all in the memory clock domain.

Parameters:
- addr_width, 24, word address width of the memory port
- burst_len, 8, data beats per burst; power of two, 2..64
- frame_words, 24576, words per frame; must be a multiple of burst_len
- holdoff, 4, idle cycles after a burst before AlmostEmpty is sampled again; covers synchronizer and queue pointer latency

Ports:
- clk  in  1  memory/queue write clock
- rst  in  1  asynchronous, active-low reset
- fb_base  in  addr_width  framebuffer word base; sampled on frame_start
- frame_start  in  1  one-cycle pulse at vertical blank start
- q_almost_empty  in  1  queue AlmostEmpty, asynchronous to clk
- q_wr_en  out  1  queue write enable
- q_data  out  32  queue write data
- mem_req  out  1  burst read request
- mem_addr  out  addr_width  burst start word address
- mem_ack  in  1  request accepted, one-cycle pulse
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  32  read beat data
- busy  out  1  burst in flight (REQ or DATA)
- frame_done  out  1  high from the end of the last burst of a frame until the next frame_start

Behaviour:
- Reset (rst=0, async): state IDLE; q_wr_en=0, q_data=0, mem_req=0, mem_addr=0, busy=0, frame_done=1, words_left=0, holdoff counter=0, flush=0, sync flops=1.
- q_almost_empty passes through a 2-flop synchronizer; ae_s is the second flop's output.
- States:
  - IDLE: go to REQ when words_left>0, ae_s=1, holdoff counter=0 and flush=0.
  - REQ: mem_req=1, mem_addr stable. On mem_ack=1, go to DATA with beat counter=0. mem_req drops the cycle after ack.
  - DATA: count mem_rvalid beats. After beat burst_len: mem_addr += burst_len (wraps modulo 2^addr_width), words_left -= burst_len, holdoff counter=holdoff, go to IDLE.
- Burst completion: when words_left becomes 0, frame_done=1.
- Holdoff counter decrements in IDLE each cycle until it reaches 0.
- Beat path: registered, latency 1. mem_rvalid at cycle t gives q_wr_en=1 and q_data=mem_rdata at t+1. mem_rvalid outside DATA is ignored.
- Queue fullness is not checked; the AlmostEmpty threshold (32) plus one burst must fit in the queue depth.
- frame_start in IDLE: next cycle mem_addr=fb_base, words_left=frame_words, frame_done=0, holdoff counter=0.
- frame_start in REQ: the request completes its handshake (mem_req held until ack). flush=1.
- frame_start in DATA: flush=1; the remaining beats are counted but q_wr_en is held 0.
- Flush completion: after the flushed burst's last beat, load fb_base/frame_words as above, clear flush, go to IDLE.
- frame_start and the last beat in the same cycle: the flush takes effect; the current beat is still written.
- frame_start while flush=1: re-samples fb_base; otherwise no extra effect.
- Reset mid-burst: all state cleared immediately. Any memory beats still arriving are ignored.
- busy=1 in REQ and DATA.

Test Plan:
- Reset then frame_start with fb_base=0x1000, q_almost_empty=1, mem_ack 2 cycles after req, 8 back-to-back rvalid beats -> mem_addr=0x1000; 8 q_wr_en pulses each 1 cycle after rvalid with matching data; next request mem_addr=0x1008 no sooner than 4 cycles after the last beat.
- q_almost_empty=0 after frame_start -> mem_req stays 0 indefinitely. Raise q_almost_empty -> mem_req asserted 3 cycles later (2-flop sync + IDLE decision).
- frame_words=16, burst_len=8 -> exactly 2 bursts (0x1000, 0x1008), 16 writes, then frame_done=1 and no further mem_req despite AlmostEmpty=1.
- frame_start after beat 3 of a burst, fb_base=0x2000 -> beats 4-8 produce no q_wr_en; next request mem_addr=0x2000 with words_left=frame_words.
- Gapped rvalid (beats every 3 cycles) and ack delayed 10 cycles -> mem_req held stable 10 cycles; write count still 8; busy high throughout.
- rst low mid-DATA -> all outputs at reset values asynchronously; stray rvalid after release produces no q_wr_en.
